rnd_arbiter: RTL and testbench
==============================

Name: rnd_arbiter

Overview:
Shared random-number server for the polyphonic voice bank. NUM_REQ voice requesters (noise oscillators, random LFO, detune jitter) contend for a single 32-bit LFSR instead of each instantiating its own generator. Round-robin arbitration picks one requester per transaction, steps the LFSR WIDTH times to produce a fresh word, then returns it with a one-cycle grant pulse. A seed port allows reseeding at runtime.

Parameters:
NUM_REQ, 8, number of requesters (2..16)
WIDTH, 8, random word width in bits (1..32); also the number of LFSR steps per word
INIT_VAL, 32'h12345678, LFSR value after reset and substitute for a zero seed

Ports:
clk  input  1  system clock, all logic on rising edge
rst_n  input  1  asynchronous active-low reset
req  input  NUM_REQ  per-requester request level; held high until the matching gnt bit
seed_load  input  1  single-cycle strobe that loads seed_val into the LFSR
seed_val  input  32  new LFSR seed
gnt  output  NUM_REQ  one-hot grant pulse, one cycle long
rnd_out  output  WIDTH  random word, valid only while rnd_valid is high
rnd_valid  output  1  high for exactly the cycle gnt is non-zero
busy  output  1  high in the FILL and GRANT states

Behaviour:
- Reset (async on rst_n low): lfsr=INIT_VAL; state=IDLE; gnt=0; rnd_out=0; rnd_valid=0; busy=0; rr_ptr=NUM_REQ-1, so req[0] has top priority first; fill_cnt=0.
- LFSR step: lfsr <= {lfsr[30:0], lfsr[30]^lfsr[27]}. It steps only in FILL and holds in every other state, so the output sequence is deterministic regardless of request timing.
- FSM states:
  - IDLE:
    - If any req bit is set, winner = the first set bit searching upward (modulo NUM_REQ) from rr_ptr+1.
    - Latch the winner index, clear fill_cnt, and go to FILL.
  - FILL:
    - Step the LFSR once per cycle and increment fill_cnt.
    - After WIDTH steps, check req[winner]. If it is still high, go to GRANT. If it has dropped, go to IDLE with no grant and leave rr_ptr unchanged; the advanced LFSR is retained.
  - GRANT:
    - gnt[winner]=1, rnd_valid=1, rnd_out=lfsr[WIDTH-1:0] (all registered outputs), rr_ptr=winner.
    - Next state is IDLE.
    - On the following cycle gnt=0 and rnd_valid=0; rnd_out holds its last value.
- Latency: a req first seen in IDLE at cycle t gives the grant at cycle t+WIDTH+1. Minimum spacing between grants is WIDTH+2 cycles.
- Requester handshake: the requester must drop req in the cycle after its gnt, or it re-enters arbitration as a new request. If it does re-enter, round-robin still serves every other pending requester first.
- seed_load has the highest priority in any state:
  - lfsr = (seed_val==0) ? INIT_VAL : seed_val, which avoids the all-zero lockup.
  - The state is forced to IDLE and any FILL in progress is aborted with no grant; rr_ptr is unchanged.
  - If seed_load is high in GRANT, the grant pulse for that cycle still fires. The load happens on the same edge that leaves GRANT.
- A simultaneous req and seed_load in IDLE takes the load only; arbitration starts the next cycle.
- NUM_REQ=1 degenerates to a request/grant pacer with no fairness logic.

Test Plan:
- Reset, WIDTH=8, hold req=8'h01 until gnt, request issued at cycle t -> gnt=8'h01 and rnd_out=8'h07 at t+9. Internal lfsr is 32'h34567807.
- Continue from the previous state, pulse req[0] again -> second word rnd_out=8'h2D, lfsr=32'h5678072D.
- Hold req=8'hFF continuously, each requester dropping req one cycle after its own gnt -> grant order 0,1,2,...,7. Successive grants are spaced exactly 10 cycles apart.
- Start a request, then drop req[winner] at FILL cycle 4 -> no gnt and no rnd_valid. FSM returns to IDLE, and the next request is served by the same round-robin order.
- seed_load with seed_val=0 during FILL -> FILL aborted, lfsr=32'h12345678. The next grant yields rnd_out=8'h07.
- Assert rst_n low mid-FILL -> all outputs are 0 immediately. After release, the first request to req[3] (with req[0] also high) grants req[0] first.

Source files
------------

// File: rtl/rnd_arbiter.sv
// rnd_arbiter: shared random-number server for the voice bank.
// NUM_REQ requesters contend round-robin for one 32-bit LFSR. Each transaction
// steps the LFSR WIDTH times and hands the low WIDTH bits to the winner together
// with a one-cycle grant pulse. A seed strobe reseeds the LFSR at any time.
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   req        per-requester request level, held until the matching gnt bit
//   seed_load  single-cycle strobe loading seed_val into the LFSR
//   seed_val   new LFSR seed (zero is replaced by INIT_VAL)
//   gnt        one-hot grant pulse, one cycle long
//   rnd_out    random word, valid while rnd_valid is high, held afterwards
//   rnd_valid  high for exactly the grant cycle
//   busy       high while filling or granting
module rnd_arbiter #(
   parameter int unsigned NUM_REQ  = 8,
   parameter int unsigned WIDTH    = 8,
   parameter logic [31:0] INIT_VAL = 32'h12345678
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [NUM_REQ-1:0] req,
   input  logic               seed_load,
   input  logic [31:0]        seed_val,
   output logic [NUM_REQ-1:0] gnt,
   output logic [WIDTH-1:0]   rnd_out,
   output logic               rnd_valid,
   output logic               busy
);

   localparam int unsigned IdxW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int unsigned CntW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {StIdle, StFill, StGrant} state_e;

   state_e             state_q;
   logic [31:0]        lfsr_q;
   logic [IdxW-1:0]    rr_ptr_q;
   logic [IdxW-1:0]    winner_q;
   logic [CntW-1:0]    fill_cnt_q;
   logic [NUM_REQ-1:0] gnt_q;
   logic [WIDTH-1:0]   rnd_out_q;
   logic               rnd_valid_q;
   logic               busy_q;

   logic [31:0]        lfsr_step;
   logic [IdxW-1:0]    pick_idx;
   logic               pick_found;

   assign lfsr_step = {lfsr_q[30:0], lfsr_q[30] ^ lfsr_q[27]};

   // Round-robin search: first set req bit strictly after rr_ptr, wrapping.
   always_comb begin
      int unsigned     cand;
      logic [IdxW-1:0] idx;
      pick_found = 1'b0;
      pick_idx   = rr_ptr_q;
      for (int unsigned k = 1; k <= NUM_REQ; k++) begin
         cand = (32'(rr_ptr_q) + k) % NUM_REQ;
         idx  = IdxW'(cand);
         if (!pick_found && req[idx]) begin
            pick_found = 1'b1;
            pick_idx   = idx;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= StIdle;
         lfsr_q      <= INIT_VAL;
         rr_ptr_q    <= IdxW'(NUM_REQ - 1);
         winner_q    <= '0;
         fill_cnt_q  <= '0;
         gnt_q       <= '0;
         rnd_out_q   <= '0;
         rnd_valid_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         // Grant and valid are single-cycle pulses by default.
         gnt_q       <= '0;
         rnd_valid_q <= 1'b0;
         if (seed_load) begin
            // Reseed wins over everything; an in-flight fill is dropped.
            lfsr_q  <= (seed_val == 32'd0) ? INIT_VAL : seed_val;
            state_q <= StIdle;
            busy_q  <= 1'b0;
         end else begin
            unique case (state_q)
               StIdle: begin
                  if (pick_found) begin
                     winner_q   <= pick_idx;
                     fill_cnt_q <= '0;
                     state_q    <= StFill;
                     busy_q     <= 1'b1;
                  end
               end
               StFill: begin
                  lfsr_q     <= lfsr_step;
                  fill_cnt_q <= fill_cnt_q + CntW'(1);
                  if (fill_cnt_q == CntW'(WIDTH - 1)) begin
                     if (req[winner_q]) begin
                        state_q         <= StGrant;
                        gnt_q[winner_q] <= 1'b1;
                        rnd_valid_q     <= 1'b1;
                        rnd_out_q       <= lfsr_step[WIDTH-1:0];
                        rr_ptr_q        <= winner_q;
                     end else begin
                        // Requester gave up: no grant, fairness pointer untouched.
                        state_q <= StIdle;
                        busy_q  <= 1'b0;
                     end
                  end
               end
               StGrant: begin
                  state_q <= StIdle;
                  busy_q  <= 1'b0;
               end
               default: begin
                  state_q <= StIdle;
                  busy_q  <= 1'b0;
               end
            endcase
         end
      end
   end

   assign gnt       = gnt_q;
   assign rnd_out   = rnd_out_q;
   assign rnd_valid = rnd_valid_q;
   assign busy      = busy_q;

endmodule

// File: tb/tb_rnd_arbiter.sv
// Self-checking bench for rnd_arbiter (NUM_REQ=8, WIDTH=8): directed scenarios
// followed by randomized request/seed traffic against a behavioural model.
module tb_rnd_arbiter;

   localparam int          N    = 8;
   localparam int          W    = 8;
   localparam logic [31:0] INIT = 32'h12345678;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic [N-1:0] req = '0;
   logic         seed_load = 1'b0;
   logic [31:0]  seed_val = '0;
   logic [N-1:0] gnt;
   logic [W-1:0] rnd_out;
   logic         rnd_valid;
   logic         busy;

   rnd_arbiter #(
      .NUM_REQ (N),
      .WIDTH   (W),
      .INIT_VAL(INIT)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .req      (req),
      .seed_load(seed_load),
      .seed_val (seed_val),
      .gnt      (gnt),
      .rnd_out  (rnd_out),
      .rnd_valid(rnd_valid),
      .busy     (busy)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // Behavioural model: transaction view with a countdown of LFSR steps left.
   logic [31:0]  m_lfsr;
   bit           m_active;   // a transaction (fill or grant) is in flight
   int           m_left;     // LFSR steps still owed to the current winner
   int           m_win;
   int           m_last;     // most recently granted requester
   logic [N-1:0] m_gnt;
   logic [W-1:0] m_rnd;
   bit           m_valid;

   function automatic logic [31:0] lfsr_adv(input logic [31:0] v);
      return (v << 1) | ((v >> 30) ^ (v >> 27)) & 32'd1;
   endfunction

   function automatic int rr_pick(input int last, input logic [N-1:0] r);
      for (int k = 1; k <= N; k++)
         if (r[(last + k) % N]) return (last + k) % N;
      return -1;
   endfunction

   task automatic model_reset();
      m_lfsr = INIT; m_active = 0; m_left = 0; m_win = 0; m_last = N - 1;
      m_gnt = '0; m_rnd = '0; m_valid = 0;
   endtask

   // One rising edge worth of behaviour, using the inputs held over the cycle.
   task automatic model_step();
      bit was_grant;
      was_grant = m_valid;
      m_gnt = '0;
      m_valid = 0;
      if (seed_load) begin
         m_lfsr = (seed_val == 0) ? INIT : seed_val;
         m_active = 0;
      end else if (was_grant) begin
         m_active = 0;
      end else if (!m_active) begin
         if (req != 0) begin
            m_win = rr_pick(m_last, req);
            m_left = W;
            m_active = 1;
         end
      end else begin
         m_lfsr = lfsr_adv(m_lfsr);
         m_left--;
         if (m_left == 0) begin
            if (req[m_win]) begin
               m_gnt = N'(1) << m_win;
               m_valid = 1;
               m_rnd = m_lfsr[W-1:0];
               m_last = m_win;
            end else begin
               m_active = 0;
            end
         end
      end
   endtask

   task automatic check_outputs();
      check_eq("gnt", 32'(gnt), 32'(m_gnt));
      check_eq("rnd_valid", 32'(rnd_valid), 32'(m_valid));
      check_eq("rnd_out", 32'(rnd_out), 32'(m_rnd));
      check_eq("busy", 32'(busy), 32'(m_active));
      check_eq("lfsr", dut.lfsr_q, m_lfsr);
   endtask

   // Advance one clock; outputs are compared 1 time unit after the edge.
   task automatic tick();
      @(posedge clk);
      if (rst_n) model_step();
      #1;
      check_outputs();
   endtask

   task automatic wait_gnt(output int n, output logic [N-1:0] g);
      n = 0;
      g = '0;
      for (int i = 0; i < 60; i++) begin
         tick();
         n++;
         if (gnt != 0) begin
            g = gnt;
            return;
         end
      end
      check_eq("gnt_timeout", 32'(gnt != 0), 32'd1);
   endtask

   task automatic do_reset();
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      req = '0;
      seed_load = 1'b0;
      #2;
      model_reset();
      check_outputs();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int           n;
      int           sp;
      logic [N-1:0] g;
      logic [N-1:0] prev_g;
      logic [N-1:0] acc;

      // Reset state
      model_reset();
      #12;
      check_eq("rst_gnt", 32'(gnt), 32'd0);
      check_eq("rst_valid", 32'(rnd_valid), 32'd0);
      check_eq("rst_busy", 32'(busy), 32'd0);
      check_eq("rst_lfsr", dut.lfsr_q, INIT);
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      // First word from reset: grant 9 cycles after the request
      req = 8'h01;
      wait_gnt(n, g);
      check_eq("t1_latency", n, 32'd9);
      check_eq("t1_gnt", 32'(g), 32'h01);
      check_eq("t1_word", 32'(rnd_out), 32'h07);
      check_eq("t1_lfsr", dut.lfsr_q, 32'h34567807);
      tick();
      req = '0;
      tick();

      // Second word continues the sequence
      req = 8'h01;
      wait_gnt(n, g);
      check_eq("t2_word", 32'(rnd_out), 32'h2D);
      check_eq("t2_lfsr", dut.lfsr_q, 32'h5678072D);
      tick();
      req = '0;
      tick();

      // All requesting: order 0..7, grants exactly 10 cycles apart
      do_reset();
      req = 8'hFF;
      for (int k = 0; k < N; k++) begin
         wait_gnt(n, g);
         check_eq("t3_order", 32'(g), 32'(N'(1) << k));
         if (k > 0) check_eq("t3_spacing", sp + n, 32'd10);
         tick();
         req = req & ~g;
         sp = 1;
      end
      check_eq("t3_req_empty", 32'(req), 32'd0);

      // Winner abandons mid-fill: no grant, fairness pointer unchanged
      req = 8'h04;
      repeat (4) tick();
      req = '0;
      acc = '0;
      for (int i = 0; i < 15; i++) begin
         tick();
         acc = acc | gnt;
      end
      check_eq("t4_no_gnt", 32'(acc), 32'd0);
      req = 8'h0C;
      wait_gnt(n, g);
      check_eq("t4_next", 32'(g), 32'h04);
      tick();
      req = req & ~g;
      tick();
      req = '0;
      tick();

      // Zero seed during fill restores INIT and aborts the fill
      req = 8'h10;
      repeat (4) tick();
      seed_load = 1'b1;
      seed_val = 32'd0;
      tick();
      seed_load = 1'b0;
      check_eq("t5_lfsr", dut.lfsr_q, INIT);
      check_eq("t5_busy", 32'(busy), 32'd0);
      wait_gnt(n, g);
      check_eq("t5_gnt", 32'(g), 32'h10);
      check_eq("t5_word", 32'(rnd_out), 32'h07);
      tick();
      req = '0;
      tick();

      // Async reset mid-fill clears outputs at once; req[0] wins after release
      req = 8'h08;
      repeat (3) tick();
      #2;
      rst_n = 1'b0;
      #1;
      model_reset();
      check_eq("t6_busy", 32'(busy), 32'd0);
      check_eq("t6_rnd_out", 32'(rnd_out), 32'd0);
      check_eq("t6_gnt", 32'(gnt), 32'd0);
      check_outputs();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      req = 8'h09;
      wait_gnt(n, g);
      check_eq("t6_first", 32'(g), 32'h01);
      tick();
      req = req & ~g;
      wait_gnt(n, g);
      check_eq("t6_second", 32'(g), 32'h08);
      tick();
      req = '0;

      // Randomized traffic: requesters drop the cycle after their grant,
      // occasionally abandon, and the seed is reloaded now and then.
      prev_g = '0;
      for (int c = 0; c < 3000; c++) begin
         tick();
         req = req & ~prev_g;
         prev_g = gnt;
         for (int i = 0; i < N; i++) begin
            if (!req[i] && !prev_g[i] && $urandom_range(0, 7) == 0) req[i] = 1'b1;
            else if (req[i] && !prev_g[i] && $urandom_range(0, 63) == 0) req[i] = 1'b0;
         end
         seed_load = ($urandom_range(0, 99) == 0);
         seed_val = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
      end
      tick();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
